muldiv_sequencer: RTL

Multi-cycle sequencer for the HI/LO register pair. It accepts MULT/MULTU/DIV/DIVU requests from execute and runs a 32-iteration shift-add multiply or restoring divide. It then issues a single HI/LO write toward writeback and stalls the pipeline for any HI/LO access or new mult/div request while an operation is in flight.

---
 rtl/muldiv_sequencer.sv | 134 +++++++++++++
 1 files changed

// File: rtl/muldiv_sequencer.sv
// HI/LO multiply/divide sequencer: 32-iteration shift-add multiply or restoring
// divide, single HI/LO write on completion, pipeline stall while in flight.
module muldiv_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_valid,
  input  logic [1:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  output logic        start_ready,
  input  logic        hilo_read,
  input  logic        flush,
  output logic        stall,
  output logic        busy,
  output logic        done,
  output logic        hi_write,
  output logic        lo_write,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t      state, state_nxt;
  logic [5:0]  cnt;
  logic [63:0] acc, acc_nxt, prod_fix;
  logic [31:0] opa, opb, opa_nxt, opb_nxt, raw_a;
  logic [31:0] abs_a, abs_b, mul_addend, hi_fix, lo_fix;
  logic [32:0] mul_sum, rem_sh;
  logic [33:0] trial;
  logic        neg_res, neg_rem, div_zero;
  logic        accept, last, is_signed;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    start_ready = (state == IDLE);
    busy        = (state != IDLE);
    done        = (state == DONE);
    hi_write    = done;
    lo_write    = done;
    stall       = busy & (hilo_read | start_valid);
    accept      = start_valid & (state == IDLE) & ~flush;
    last        = (cnt == 6'd31);
    state_nxt   = state;
    case (state)
      IDLE:     if (accept) state_nxt = op[1] ? DIV : MUL;
      MUL, DIV: if (flush) state_nxt = IDLE;
                else if (last) state_nxt = DONE;
      DONE:     state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    is_signed  = ~op[0];
    abs_a      = (is_signed & src_a[31]) ? (32'd0 - src_a) : src_a;
    abs_b      = (is_signed & src_b[31]) ? (32'd0 - src_b) : src_b;
    mul_addend = opb[0] ? opa : 32'd0;
    mul_sum    = {1'b0, acc[63:32]} + {1'b0, mul_addend};
    rem_sh     = {acc[63:32], opa[31]};
    trial      = {1'b0, rem_sh} - {2'b00, opb};
    acc_nxt    = acc;
    opa_nxt    = opa;
    opb_nxt    = opb;
    if (state == MUL) begin
      acc_nxt = {mul_sum, acc[31:1]};
      opb_nxt = {1'b0, opb[31:1]};
    end else if (state == DIV) begin
      if (!trial[33]) acc_nxt = {trial[31:0], acc[30:0], 1'b1};
      else            acc_nxt = {rem_sh[31:0], acc[30:0], 1'b0};
      opa_nxt = {opa[30:0], 1'b0};
    end
    // sign fix is taken from the final iteration's value, not the stored acc
    prod_fix = neg_res ? (64'd0 - acc_nxt) : acc_nxt;
    if (state == MUL) begin
      hi_fix = prod_fix[63:32];
      lo_fix = prod_fix[31:0];
    end else if (div_zero) begin
      hi_fix = raw_a;
      lo_fix = '1;
    end else begin
      hi_fix = neg_rem ? (32'd0 - acc_nxt[63:32]) : acc_nxt[63:32];
      lo_fix = neg_res ? (32'd0 - acc_nxt[31:0])  : acc_nxt[31:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt      <= '0;
      acc      <= '0;
      opa      <= '0;
      opb      <= '0;
      raw_a    <= '0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
      hi_out   <= '0;
      lo_out   <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          cnt      <= '0;
          acc      <= '0;
          opa      <= abs_a;
          opb      <= abs_b;
          raw_a    <= src_a;
          neg_res  <= is_signed & (src_a[31] ^ src_b[31]);
          neg_rem  <= is_signed & src_a[31];
          div_zero <= (src_b == 32'd0);
        end
        MUL, DIV: if (flush) begin
          cnt <= '0;
        end else begin
          acc <= acc_nxt;
          opa <= opa_nxt;
          opb <= opb_nxt;
          if (last) begin
            cnt    <= '0;
            hi_out <= hi_fix;
            lo_out <= lo_fix;
          end else begin
            cnt <= cnt + 6'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
